// File: rtl/eth_rx_frame_decoder.sv
// Receive-side Ethernet frame decoder: filters on destination MAC and EtherType,
// strips the header, captures the source MAC and packs payload into wide beats.
module eth_rx_frame_decoder #(
  parameter int unsigned BYTES_PER_BEAT = 4,
  parameter int unsigned HDR_BYTES      = 14,
  parameter logic [47:0] MAC_ADDR       = 48'h000A35000102,
  parameter bit          ACCEPT_BCAST   = 1'b1,
  parameter logic [15:0] ETHERTYPE      = 16'h88B5,
  parameter int unsigned MAX_PAYLOAD    = 1500,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic                          axi_tclk,
  input  logic                          axi_treset,
  input  logic                          enable_rx_decode,
  input  logic [7:0]                    rx_axis_tdata,
  input  logic                          rx_axis_tvalid,
  input  logic                          rx_axis_tlast,
  output logic                          rx_axis_tready,
  output logic [8*BYTES_PER_BEAT-1:0]   tdata,
  output logic [BYTES_PER_BEAT-1:0]     tkeep,
  output logic                          tvalid,
  output logic                          tlast,
  input  logic                          tready,
  output logic [47:0]                   rx_src_mac,
  output logic                          frame_error,
  output logic [COUNT_WIDTH-1:0]        accept_cnt,
  output logic [COUNT_WIDTH-1:0]        drop_cnt
);

  localparam int unsigned DW     = 8 * BYTES_PER_BEAT;
  localparam int unsigned LANE_W = (BYTES_PER_BEAT > 1) ? $clog2(BYTES_PER_BEAT) : 1;
  localparam int unsigned HCW    = $clog2(HDR_BYTES + 1);
  localparam int unsigned PCW    = $clog2(MAX_PAYLOAD + 1);

  typedef enum logic [1:0] {HEADER, PAYLOAD, DROP} state_e;

  state_e                 state_q, state_d;
  logic [HCW-1:0]         hdr_cnt_q, hdr_cnt_d;
  logic [PCW-1:0]         pay_cnt_q, pay_cnt_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [DW-1:0]          pack_q, pack_d;
  logic [BYTES_PER_BEAT-1:0] pkeep_q, pkeep_d;
  logic                   mac_ok_q, mac_ok_d, bc_ok_q, bc_ok_d, type_ok_q, type_ok_d;
  logic [47:0]            shadow_q, shadow_d;
  logic [47:0]            src_q, src_d;
  logic [DW-1:0]          tdata_q, tdata_d;
  logic [BYTES_PER_BEAT-1:0] tkeep_q, tkeep_d;
  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic                   ferr_q, ferr_d;
  logic [COUNT_WIDTH-1:0] acc_q, acc_d, drop_q, drop_d;

  logic                   rx_ready_c, xfer_c;
  logic [7:0]             exp_mac_byte_c;
  logic                   mac_ok_n_c, bc_ok_n_c, type_ok_n_c, hdr_match_c;
  logic [DW-1:0]          beat_data_c;
  logic [BYTES_PER_BEAT-1:0] beat_keep_c;
  logic                   over_c, emit_c;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  // Input ready: only payload bytes wait on the output register.
  always_comb begin
    rx_ready_c = 1'b1;
    if (state_q == PAYLOAD) rx_ready_c = !tvalid_q || tready;
    if (axi_treset) rx_ready_c = 1'b0;
  end
  assign xfer_c = rx_axis_tvalid && rx_ready_c;

  // Running header match flags including the byte currently on the bus.
  always_comb begin
    exp_mac_byte_c = '0;
    for (int i = 0; i < 6; i++) begin
      if (hdr_cnt_q == HCW'(i)) exp_mac_byte_c = MAC_ADDR[47-8*i -: 8];
    end
    mac_ok_n_c  = mac_ok_q;
    bc_ok_n_c   = bc_ok_q;
    type_ok_n_c = type_ok_q;
    if (hdr_cnt_q < HCW'(6)) begin
      mac_ok_n_c = (hdr_cnt_q == '0 || mac_ok_q) && (rx_axis_tdata == exp_mac_byte_c);
      bc_ok_n_c  = (hdr_cnt_q == '0 || bc_ok_q) && (rx_axis_tdata == 8'hFF);
    end
    if (hdr_cnt_q == HCW'(12)) type_ok_n_c = (rx_axis_tdata == ETHERTYPE[15:8]);
    if (hdr_cnt_q == HCW'(13)) type_ok_n_c = type_ok_q && (rx_axis_tdata == ETHERTYPE[7:0]);
    hdr_match_c = (mac_ok_n_c || (ACCEPT_BCAST && bc_ok_n_c)) && type_ok_n_c;
  end

  // Pack register merged with the current byte at its lane.
  always_comb begin
    beat_data_c = pack_q;
    beat_keep_c = pkeep_q;
    for (int i = 0; i < BYTES_PER_BEAT; i++) begin
      if (lane_q == LANE_W'(i)) begin
        beat_data_c[8*i +: 8] = rx_axis_tdata;
        beat_keep_c[i]        = 1'b1;
      end
    end
    over_c = !rx_axis_tlast && (pay_cnt_q == PCW'(MAX_PAYLOAD - 1));
    emit_c = (lane_q == LANE_W'(BYTES_PER_BEAT - 1)) || rx_axis_tlast || over_c;
  end

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    pay_cnt_d = pay_cnt_q;
    lane_d    = lane_q;
    pack_d    = pack_q;
    pkeep_d   = pkeep_q;
    mac_ok_d  = mac_ok_q;
    bc_ok_d   = bc_ok_q;
    type_ok_d = type_ok_q;
    shadow_d  = shadow_q;
    src_d     = src_q;
    tdata_d   = tdata_q;
    tkeep_d   = tkeep_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    ferr_d    = 1'b0;
    acc_d     = acc_q;
    drop_d    = drop_q;

    if (tvalid_q && tready) tvalid_d = 1'b0;

    unique case (state_q)
      HEADER: begin
        if (xfer_c) begin
          mac_ok_d  = mac_ok_n_c;
          bc_ok_d   = bc_ok_n_c;
          type_ok_d = type_ok_n_c;
          if (hdr_cnt_q >= HCW'(6) && hdr_cnt_q < HCW'(12))
            shadow_d = {shadow_q[39:0], rx_axis_tdata};
          if (hdr_cnt_q == '0 && !enable_rx_decode) begin
            drop_d    = sat_inc(drop_q);
            hdr_cnt_d = '0;
            if (!rx_axis_tlast) state_d = DROP;
          end else if (hdr_cnt_q == HCW'(HDR_BYTES - 1)) begin
            hdr_cnt_d = '0;
            if (hdr_match_c && !rx_axis_tlast) begin
              state_d = PAYLOAD;
              src_d   = shadow_q;
            end else begin
              drop_d = sat_inc(drop_q);
              if (!rx_axis_tlast) state_d = DROP;
            end
          end else if (rx_axis_tlast) begin
            ferr_d    = 1'b1;
            drop_d    = sat_inc(drop_q);
            hdr_cnt_d = '0;
          end else begin
            hdr_cnt_d = hdr_cnt_q + HCW'(1);
          end
        end
      end
      PAYLOAD: begin
        if (xfer_c) begin
          pay_cnt_d = pay_cnt_q + PCW'(1);
          if (emit_c) begin
            tdata_d  = beat_data_c;
            tkeep_d  = beat_keep_c;
            tvalid_d = 1'b1;
            tlast_d  = rx_axis_tlast || over_c;
            pack_d   = '0;
            pkeep_d  = '0;
            lane_d   = '0;
          end else begin
            pack_d  = beat_data_c;
            pkeep_d = beat_keep_c;
            lane_d  = lane_q + LANE_W'(1);
          end
          if (rx_axis_tlast) begin
            acc_d     = sat_inc(acc_q);
            pay_cnt_d = '0;
            state_d   = HEADER;
          end else if (over_c) begin
            // Truncate at the limit; the tail is swallowed in DROP.
            ferr_d    = 1'b1;
            acc_d     = sat_inc(acc_q);
            pay_cnt_d = '0;
            state_d   = DROP;
          end
        end
      end
      DROP: begin
        if (xfer_c && rx_axis_tlast) state_d = HEADER;
      end
      default: state_d = HEADER;
    endcase
  end

  always_ff @(posedge axi_tclk or posedge axi_treset) begin
    if (axi_treset) begin
      state_q   <= HEADER;
      hdr_cnt_q <= '0;
      pay_cnt_q <= '0;
      lane_q    <= '0;
      pack_q    <= '0;
      pkeep_q   <= '0;
      mac_ok_q  <= 1'b0;
      bc_ok_q   <= 1'b0;
      type_ok_q <= 1'b0;
      shadow_q  <= '0;
      src_q     <= '0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      ferr_q    <= 1'b0;
      acc_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      lane_q    <= lane_d;
      pack_q    <= pack_d;
      pkeep_q   <= pkeep_d;
      mac_ok_q  <= mac_ok_d;
      bc_ok_q   <= bc_ok_d;
      type_ok_q <= type_ok_d;
      shadow_q  <= shadow_d;
      src_q     <= src_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      ferr_q    <= ferr_d;
      acc_q     <= acc_d;
      drop_q    <= drop_d;
    end
  end

  assign rx_axis_tready = rx_ready_c;
  assign tdata          = tdata_q;
  assign tkeep          = tkeep_q;
  assign tvalid         = tvalid_q;
  assign tlast          = tlast_q;
  assign rx_src_mac     = src_q;
  assign frame_error    = ferr_q;
  assign accept_cnt     = acc_q;
  assign drop_cnt       = drop_q;

endmodule

// File: doc/eth_rx_frame_decoder.md
# eth_rx_frame_decoder

Parametrised receive-side frame decoder between the RGMII MAC RX AXI-Stream (8-bit) and the on-board command/data path.
- Filters each frame on destination MAC and EtherType, strips a configurable header and captures the source MAC.
- Packs the payload into BYTES_PER_BEAT-byte output beats with tkeep, and enforces a maximum payload length.
- Counts accepted and dropped frames.

## Interface
- BYTES_PER_BEAT, 4: output beat width in bytes; legal values 1, 2, 4, 8.
- HDR_BYTES, 14: header bytes stripped per frame; minimum 14; bytes 14..HDR_BYTES-1 are ignored.
- MAC_ADDR, 48'h000A35000102: local MAC; frame byte 0 compares against [47:40].
- ACCEPT_BCAST, 1: also accept destination FF:FF:FF:FF:FF:FF.
- ETHERTYPE, 16'h88B5: required type; frame byte 12 compares against [15:8], byte 13 against [7:0].
- MAX_PAYLOAD, 1500: maximum forwarded payload bytes per frame.
- COUNT_WIDTH, 32: frame counter width.
- axi_tclk  in  1  the single clock.
- axi_treset  in  1  asynchronous, active-high reset.
- enable_rx_decode  in  1  sampled at frame start; 0 drops whole frames.
- rx_axis_tdata  in  8  MAC RX byte.
- rx_axis_tvalid  in  1  input valid.
- rx_axis_tlast  in  1  last byte of frame.
- rx_axis_tready  out  1  input ready.
- tdata  out  8*BYTES_PER_BEAT  payload beat; first byte is in [7:0].
- tkeep  out  BYTES_PER_BEAT  byte enables.
- tvalid  out  1  output valid.
- tlast  out  1  last beat of payload.
- tready  in  1  downstream ready.
- rx_src_mac  out  48  source MAC (frame bytes 6..11) of the current or last accepted frame.
- frame_error  out  1  one-cycle pulse on a runt or oversize frame.
- accept_cnt  out  COUNT_WIDTH  frames forwarded; saturating.
- drop_cnt  out  COUNT_WIDTH  frames dropped; saturating.

## Operation
- A byte is transferred when rx_axis_tvalid & rx_axis_tready are both high.
- States are HEADER, PAYLOAD and DROP. Reset enters HEADER with hdr_cnt=0.
- HEADER:
  - rx_axis_tready=1.
  - On the byte with hdr_cnt=0, enable_rx_decode is sampled. If it is 0, go to DROP and increment drop_cnt; if that byte also has tlast, stay in HEADER.
  - Bytes 0-5 and 12-13 update running match flags. Bytes 6-11 load a shadow source-MAC register.
  - Runt: tlast on any header byte before byte HDR_BYTES-1 → pulse frame_error, drop_cnt++, hdr_cnt=0, stay in HEADER.
  - Last header byte with a match:
    - without tlast → PAYLOAD; rx_src_mac is updated from the shadow register.
    - with tlast (zero payload) → drop_cnt++, no error, stay in HEADER.
  - Last header byte with no match → drop_cnt++; go to DROP, or stay in HEADER if that byte carries tlast.
- PAYLOAD:
  - rx_axis_tready = !tvalid | tready.
  - Each byte goes into the pack register at lane pay_cnt mod BYTES_PER_BEAT.
  - A beat is emitted when the lane is full or the byte carries tlast. tkeep marks filled lanes; unfilled lanes of tdata are 0.
  - tlast on input → output tlast=1, accept_cnt++, go to HEADER.
  - Oversize: byte number MAX_PAYLOAD is accepted without tlast → emit it as a tlast beat, pulse frame_error, accept_cnt++, go to DROP.
- DROP: rx_axis_tready=1; discard bytes until tlast, then go to HEADER.
- enable_rx_decode changes mid-frame have no effect.
- Counters saturate at all-ones.
- Reset asserted mid-frame: all state clears. The frame tail arriving after reset is parsed as a new header; this is accepted behaviour.

## Timing
- Reset values: tvalid=0, tdata=0, tkeep=0, tlast=0, frame_error=0, rx_src_mac=0, accept_cnt=0, drop_cnt=0.
- rx_axis_tready is forced 0 while axi_treset is high.
- Output latency: a beat's final byte accepted at cycle N gives tvalid=1 at N+1.
- With BYTES_PER_BEAT=1 and tready held high, throughput is 1 byte per cycle.
- tvalid, tdata, tkeep and tlast are held stable while tvalid & !tready.
- frame_error, accept_cnt and drop_cnt update the cycle after the deciding byte is accepted.
- A new frame's header can be accepted the cycle after the previous tlast, including while the last output beat still waits for tready.

## Test plan
- Good frame: dest 00:0A:35:00:01:02, type 88B5, 10-byte payload 01..0A, tready=1 → beats 0x04030201/keep 1111, 0x08070605/keep 1111, 0x00000A09/keep 0011 with tlast; accept_cnt=1; rx_src_mac equals bytes 6-11.
- Wrong MAC 00:0A:35:00:01:03, then broadcast with type 88B5 and 4-byte payload → first frame: no output, drop_cnt=1. Second frame: one beat, keep 1111, tlast; accept_cnt=1.
- Runt: 9-byte frame ending in tlast → frame_error pulses once, drop_cnt=1; a following good frame decodes normally.
- Oversize with MAX_PAYLOAD=8: 12-byte payload → two beats, the second with tlast; frame_error pulses; 4 tail bytes discarded; accept_cnt=1.
- Backpressure: hold tready=0 for 32 cycles mid-payload → rx_axis_tready=0 while tvalid is pending; no byte lost or duplicated; tdata stable.
- enable_rx_decode=0 at frame start, raised mid-frame → whole frame dropped, drop_cnt=1; the next frame is accepted.
